enigma_multi_rotor: RTL and testbench
=====================================

Name: enigma_multi_rotor

Overview:
Parametrised successor to the two-rotor enigma core, with configurable symbol width and rotor count.
- Input path: loadable plugboard, then a chain of NUM_ROTORS loadable substitution rotors with odometer-style stepping.
- Mode: encrypts or decrypts one symbol per cycle, selected by crypt_mode.
- Integration: sits between the code-word input stream and the registered code_out/code_valid interface.

Parameters:
- SYM_W, 6: symbol width in bits. Alphabet size N = 2^SYM_W.
- NUM_ROTORS, 3: number of rotors, 1..7.
- IDX_W, 3: table_idx width, must be >= clog2(NUM_ROTORS+1).

Ports:
- clk, in, 1: single clock, rising edge.
- srst_n, in, 1: reset. Asynchronous, active-low.
- load, in, 1: table load strobe, level-sensitive.
- encrypt, in, 1: symbol-valid strobe, level-sensitive.
- crypt_mode, in, 1: 0 = encrypt, 1 = decrypt. Sampled with each symbol.
- table_idx, in, IDX_W: 0 = plugboard; k = rotor k-1.
- code_in, in, SYM_W: table entry during load; symbol during encrypt.
- code_out, out, SYM_W: result symbol, registered.
- code_valid, out, 1: code_out is valid this cycle.

Behaviour:
- Reset (srst_n low, no clock needed):
  - state = ST_IDLE; load address counter = 0; all rotor offsets = 0; code_out = 0; code_valid = 0.
  - Table storage is not reset and must be reloaded.
- FSM states ST_IDLE, ST_LOAD, ST_READY:
  - IDLE -> LOAD when load = 1; that cycle's entry is written.
  - LOAD -> READY when load = 0.
  - READY -> LOAD when load = 1; offsets are cleared to 0.
  - encrypt is ignored outside READY. If load and encrypt are both 1 in READY, load wins and no output is produced.
- Loading:
  - Each load cycle writes code_in to entry addr of the table selected by table_idx, and writes the inverse table (inv[code_in] = addr). addr then increments mod N.
  - addr resets to 0 whenever table_idx changes or load falls.
  - table_idx values > NUM_ROTORS: write is discarded, addr still advances.
- Forward rotor k: y = T_k[(x + off_k) mod N].
- Inverse rotor k: x = (Tinv_k[y] - off_k) mod N. All offset arithmetic is SYM_W-bit wrap-around.
- Encrypt: out = rotor chain 0 .. R-1 forward, applied to P[in].
- Decrypt: out = Pinv[inverse chain R-1 .. 0 of in]. Decrypt exactly undoes encrypt at the same offsets.
- Stepping:
  - Each accepted symbol uses the current offsets, then off_0 += 1.
  - If off_0 wraps N-1 -> 0, off_1 += 1, cascading to higher rotors. The last rotor wraps silently.
  - Stepping is identical in both modes.
- Latency: symbol accepted at edge t appears on code_out with code_valid = 1 after edge t+1 (1 cycle).
  - code_valid is low in any cycle with no accepted symbol. code_out holds its last value.
  - Back-to-back symbols give full throughput, 1 per cycle.
- Async reset mid-stream: in-flight symbols are dropped; code_valid falls immediately.

Optional Feature:
ENIGMA_PIPE_EN.
- Defined:
  - A register stage follows the plugboard and each rotor lookup. Latency becomes NUM_ROTORS+2 cycles; throughput stays 1/cycle.
  - Offsets are captured per symbol and travel down the pipe with it. code_valid is pipelined alongside.
  - Entering LOAD flushes the pipe: valids cleared.
- Undefined: single-cycle combinational chain, 1-cycle latency as above.

Decomposition:
- Package enigma_pkg holds:
  - state encoding ST_IDLE/ST_LOAD/ST_READY;
  - TBL_PLUG = 0 constant;
  - offset-add/subtract helper functions parametrised on SYM_W.
- Sub-module enigma_rotor_stage: one table pair (forward + inverse), its write port, and a forward/inverse lookup with offset.
  - Instantiated NUM_ROTORS times by generate; the plugboard is an instance with offset tied to 0.

Test Plan:
1. SYM_W = 6, NUM_ROTORS = 2, all tables identity. Encrypt 0x05 three times -> code_out 0x05, 0x06, 0x07, each 1 cycle after input.
2. Same setup, 65 consecutive encrypt symbols of 0x00 -> outputs 0x00 .. 0x3F, then 0x01 (off_0 wrapped, off_1 = 1).
3. Identity tables, crypt_mode = 1. Inputs 0x05, 0x05 -> 0x05, 0x04.
4. Load the rotorA/rotorB tables from the rotor data files plus a random plugboard. Encrypt 112 plaintext symbols, reload (offsets cleared), decrypt the captured ciphertext -> original plaintext, 0 errors.
5. srst_n pulled low between clock edges during an encrypt burst -> code_valid = 0 and code_out = 0 immediately. After release, encrypt alone is ignored until load-then-idle reaches READY.
6. encrypt = 1 while in IDLE or LOAD -> code_valid stays 0 and offsets are unchanged. Under ENIGMA_PIPE_EN, test 1 outputs appear 4 cycles after input.

Source files
------------

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared FSM encoding, table ids
// and wrap-around offset helpers for the core.
package enigma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READY
  } state_t;

  localparam int TBL_PLUG = 0;

  function automatic int off_add(
    input int a,
    input int b,
    input int w
  );
    return (a + b) & ((1 << w) - 1);
  endfunction

  function automatic int off_sub(
    input int a,
    input int b,
    input int w
  );
    return (a - b) & ((1 << w) - 1);
  endfunction

endpackage

// File: rtl/enigma_multi_rotor_if.sv
// enigma_multi_rotor_if: table-load / symbol
// input bus and registered result output.
interface enigma_multi_rotor_if #(
  parameter int SYM_W = 6,
  parameter int IDX_W = 3
);

  logic             load;
  logic             encrypt;
  logic             crypt_mode;
  logic [IDX_W-1:0] table_idx;
  logic [SYM_W-1:0] code_in;
  logic [SYM_W-1:0] code_out;
  logic             code_valid;

  modport master (
    output load, encrypt, crypt_mode,
    output table_idx, code_in,
    input  code_out, code_valid
  );

  modport slave (
    input  load, encrypt, crypt_mode,
    input  table_idx, code_in,
    output code_out, code_valid
  );

endinterface

// File: rtl/enigma_rotor_stage.sv
// enigma_rotor_stage: one forward/inverse table
// pair with a write port and offset lookups.
module enigma_rotor_stage #(
  parameter int SYM_W = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [SYM_W-1:0] waddr,
  input  logic [SYM_W-1:0] wdata,
  input  logic [SYM_W-1:0] fwd_in,
  input  logic [SYM_W-1:0] fwd_off,
  input  logic [SYM_W-1:0] inv_in,
  input  logic [SYM_W-1:0] inv_off,
  output logic [SYM_W-1:0] fwd_out,
  output logic [SYM_W-1:0] inv_out
);
  import enigma_pkg::*;

  localparam int N = 1 << SYM_W;

  logic [SYM_W-1:0] fwd_t [N];
  logic [SYM_W-1:0] inv_t [N];
  logic [SYM_W-1:0] fwd_idx;

  // forward entry and its inverse are written together
  always_ff @(posedge clk) begin
    if (we) begin
      fwd_t[waddr] <= wdata;
      inv_t[wdata] <= waddr;
    end
  end

  assign fwd_idx = SYM_W'(off_add(
    int'(fwd_in), int'(fwd_off), SYM_W));

  assign fwd_out = fwd_t[fwd_idx];

  assign inv_out = SYM_W'(off_sub(
    int'(inv_t[inv_in]), int'(inv_off), SYM_W));

endmodule

// File: rtl/enigma_multi_rotor.sv
// enigma_multi_rotor: plugboard + rotor chain core.
// ENIGMA_PIPE_EN adds a register after each lookup.
module enigma_multi_rotor #(
  parameter int SYM_W      = 6,
  parameter int NUM_ROTORS = 3,
  parameter int IDX_W      = 3
) (
  input logic                 clk,
  input logic                 srst_n,
  enigma_multi_rotor_if.slave bus
);
  import enigma_pkg::*;

  localparam int R = NUM_ROTORS;
  localparam int S = NUM_ROTORS + 1;

  state_t           state_q;
  state_t           state_d;
  logic [SYM_W-1:0] addr_q;
  logic [SYM_W-1:0] waddr;
  logic [IDX_W-1:0] idx_q;
  logic [SYM_W-1:0] off_q [R];
  logic [SYM_W-1:0] off_d [R];
  logic             accept;
  logic             clr_off;
  logic             carry;

  logic [SYM_W-1:0] fwd_i [S];
  logic [SYM_W-1:0] fwd_k [S];
  logic [SYM_W-1:0] fwd_o [S];
  logic [SYM_W-1:0] inv_i [S];
  logic [SYM_W-1:0] inv_k [S];
  logic [SYM_W-1:0] inv_o [S];

  assign accept  = (state_q == ST_READY)
                && bus.encrypt && !bus.load;
  assign clr_off = (state_q == ST_READY)
                && bus.load;
  assign waddr   = (bus.table_idx != idx_q)
                 ? '0 : addr_q;

  // state register
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.load)  state_d = ST_LOAD;
      ST_LOAD:  if (!bus.load) state_d = ST_READY;
      ST_READY: if (bus.load)  state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  // load address restarts on a table switch or idle
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      addr_q <= '0;
      idx_q  <= '0;
    end else begin
      idx_q  <= bus.table_idx;
      addr_q <= bus.load ? waddr + 1'b1 : '0;
    end
  end

  // odometer step; carry ripples past wrapped rotors
  always_comb begin
    carry = accept;
    for (int k = 0; k < R; k++) begin
      off_d[k] = off_q[k]
               + {{(SYM_W-1){1'b0}}, carry};
      carry = carry && (off_q[k] == '1);
    end
  end

  // rotor offsets, cleared when tables are reloaded
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      for (int k = 0; k < R; k++) off_q[k] <= '0;
    end else if (clr_off) begin
      for (int k = 0; k < R; k++) off_q[k] <= '0;
    end else begin
      for (int k = 0; k < R; k++) off_q[k] <= off_d[k];
    end
  end

  for (genvar s = 0; s < S; s++) begin : g_stage
    enigma_rotor_stage #(.SYM_W(SYM_W)) u_stage (
      .clk     (clk),
      .we      (bus.load
                && (int'(bus.table_idx) == s)),
      .waddr   (waddr),
      .wdata   (bus.code_in),
      .fwd_in  (fwd_i[s]),
      .fwd_off (fwd_k[s]),
      .inv_in  (inv_i[s]),
      .inv_off (inv_k[s]),
      .fwd_out (fwd_o[s]),
      .inv_out (inv_o[s])
    );
  end

`ifdef ENIGMA_PIPE_EN

  logic [SYM_W-1:0] p_d   [S+1];
  logic             p_v   [S+1];
  logic             p_m   [S];
  logic [SYM_W-1:0] p_off [S][R];
  logic [SYM_W-1:0] nxt   [S];

  // slot j runs fwd stage j or inv stage S-1-j
  for (genvar s = 0; s < S; s++) begin : g_wire
    assign fwd_i[s] = p_d[s];
    assign inv_i[s] = p_d[S-1-s];
    assign nxt[s]   = p_m[s] ? inv_o[S-1-s]
                             : fwd_o[s];
    if (s == TBL_PLUG) begin : g_plug
      assign fwd_k[s] = '0;
      assign inv_k[s] = '0;
    end else begin : g_rot
      assign fwd_k[s] = p_off[s][s-1];
      assign inv_k[s] = p_off[S-1-s][s-1];
    end
  end

  // pipe advance; a load flushes in-flight symbols
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      for (int j = 0; j <= S; j++) begin
        p_d[j] <= '0;
        p_v[j] <= 1'b0;
      end
      for (int j = 0; j < S; j++) begin
        p_m[j] <= 1'b0;
        for (int k = 0; k < R; k++)
          p_off[j][k] <= '0;
      end
    end else begin
      p_v[0] <= accept;
      if (accept) begin
        p_d[0] <= bus.code_in;
        p_m[0] <= bus.crypt_mode;
        for (int k = 0; k < R; k++)
          p_off[0][k] <= off_q[k];
      end
      for (int j = 0; j < S; j++) begin
        p_v[j+1] <= p_v[j] && !bus.load;
        if (p_v[j]) p_d[j+1] <= nxt[j];
      end
      for (int j = 0; j < S-1; j++) begin
        if (p_v[j]) begin
          p_m[j+1] <= p_m[j];
          for (int k = 0; k < R; k++)
            p_off[j+1][k] <= p_off[j][k];
        end
      end
    end
  end

  assign bus.code_out   = p_d[S];
  assign bus.code_valid = p_v[S];

`else

  logic [SYM_W-1:0] out_q;
  logic             vld_q;

  // fwd chain plug->rotors, inv chain reverse
  for (genvar s = 0; s < S; s++) begin : g_wire
    if (s == TBL_PLUG) begin : g_plug
      assign fwd_i[s] = bus.code_in;
      assign fwd_k[s] = '0;
      assign inv_k[s] = '0;
    end else begin : g_rot
      assign fwd_i[s] = fwd_o[s-1];
      assign fwd_k[s] = off_q[s-1];
      assign inv_k[s] = off_q[s-1];
    end
    if (s == S-1) begin : g_last
      assign inv_i[s] = bus.code_in;
    end else begin : g_mid
      assign inv_i[s] = inv_o[s+1];
    end
  end

  // single registered result stage
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= accept;
      if (accept)
        out_q <= bus.crypt_mode ? inv_o[0]
                                : fwd_o[S-1];
    end
  end

  assign bus.code_out   = out_q;
  assign bus.code_valid = vld_q;

`endif

endmodule

// File: tb/tb_enigma_multi_rotor.sv
// tb_enigma_multi_rotor: directed checks of the
// multi-rotor core with two rotors of 64 symbols.
module tb_enigma_multi_rotor;

  localparam int SYM_W = 6;
  localparam int R     = 2;
  localparam int IDX_W = 3;
  localparam int N     = 64;
  localparam int NPT   = 112;
`ifdef ENIGMA_PIPE_EN
  localparam int LAT = R + 2;
`else
  localparam int LAT = 1;
`endif

  logic clk    = 1'b0;
  logic srst_n = 1'b1;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [SYM_W-1:0] outq [$];
  int               cycq [$];

  logic [SYM_W-1:0] ident [N];
  logic [SYM_W-1:0] rot_a [N];
  logic [SYM_W-1:0] rot_b [N];
  logic [SYM_W-1:0] plug  [N];
  logic [SYM_W-1:0] junk  [N];
  logic [SYM_W-1:0] pt    [NPT];
  logic [SYM_W-1:0] ct    [NPT];

  enigma_multi_rotor_if #(
    .SYM_W(SYM_W), .IDX_W(IDX_W)
  ) bus ();

  enigma_multi_rotor #(
    .SYM_W(SYM_W), .NUM_ROTORS(R), .IDX_W(IDX_W)
  ) dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.code_valid === 1'b1) begin
      outq.push_back(bus.code_out);
      cycq.push_back(cyc);
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_tbl(
    input int               idx,
    input int               cnt,
    input logic [SYM_W-1:0] tbl [N]
  );
    bus.load      = 1'b1;
    bus.table_idx = IDX_W'(idx);
    for (int i = 0; i < cnt; i++) begin
      bus.code_in = tbl[i];
      tick(1);
    end
  endtask

  task automatic end_load();
    bus.load = 1'b0;
    tick(1);
  endtask

  task automatic send(
    input logic [SYM_W-1:0] sym,
    input logic             mode
  );
    bus.encrypt    = 1'b1;
    bus.crypt_mode = mode;
    bus.code_in    = sym;
    tick(1);
  endtask

  task automatic quiet(input int n);
    bus.encrypt = 1'b0;
    tick(n);
  endtask

  initial begin
    int in_cyc;
    int errs;

    bus.load       = 1'b0;
    bus.encrypt    = 1'b0;
    bus.crypt_mode = 1'b0;
    bus.table_idx  = '0;
    bus.code_in    = '0;

    for (int i = 0; i < N; i++) begin
      ident[i] = SYM_W'(i);
      rot_a[i] = SYM_W'(5 * i + 3);
      rot_b[i] = SYM_W'(9 * i + 17);
      plug[i]  = SYM_W'(i ^ 42);
      junk[i]  = SYM_W'(i * 3 + 11);
    end
    for (int i = 0; i < NPT; i++)
      pt[i] = SYM_W'(i * 7);

    // reset
    #1 srst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.code_valid), 0);
    chk("rst_out", 32'(bus.code_out), 0);
    tick(2);
    srst_n = 1'b1;

    // encrypt in IDLE is ignored
    for (int i = 0; i < 3; i++) send(6'h05, 1'b0);
    quiet(LAT + 2);
    chk("idle_ign", outq.size(), 0);

    // identity tables; encrypt held during load
    bus.encrypt = 1'b1;
    load_tbl(0, N, ident);
    load_tbl(1, N, ident);
    load_tbl(2, N, ident);
    end_load();
    quiet(LAT + 2);
    chk("load_ign", outq.size(), 0);

    // test 1: 0x05 three times
    in_cyc = cyc;
    for (int i = 0; i < 3; i++) send(6'h05, 1'b0);
    quiet(LAT + 2);
    chk("t1_n", outq.size(), 3);
    chk("t1_lat", cycq[0], in_cyc + LAT);
    chk("t1_o0", 32'(outq[0]), 32'h05);
    chk("t1_o1", 32'(outq[1]), 32'h06);
    chk("t1_o2", 32'(outq[2]), 32'h07);

    // test 2: reload clears offsets, 65 zeros
    outq.delete();
    bus.encrypt = 1'b1;
    load_tbl(7, 1, ident);
    end_load();
    quiet(LAT + 2);
    chk("t2_reload", outq.size(), 0);
    for (int i = 0; i < N + 1; i++) send('0, 1'b0);
    quiet(LAT + 2);
    chk("t2_n", outq.size(), N + 1);
    for (int i = 0; i < N; i++)
      chk("t2_o", 32'(outq[i]), i);
    chk("t2_wrap", 32'(outq[N]), 32'h01);

    // test 3: decrypt identity
    outq.delete();
    load_tbl(7, 1, ident);
    end_load();
    send(6'h05, 1'b1);
    send(6'h05, 1'b1);
    quiet(LAT + 2);
    chk("t3_n", outq.size(), 2);
    chk("t3_o0", 32'(outq[0]), 32'h05);
    chk("t3_o1", 32'(outq[1]), 32'h04);

    // test 4: real tables, partial junk first,
    // then an out-of-range table write
    outq.delete();
    load_tbl(1, 10, junk);
    load_tbl(2, N, rot_b);
    load_tbl(1, N, rot_a);
    load_tbl(0, N, plug);
    load_tbl(5, N, junk);
    end_load();
    for (int i = 0; i < NPT; i++) send(pt[i], 1'b0);
    quiet(LAT + 2);
    chk("t4_enc_n", outq.size(), NPT);
    for (int i = 0; i < NPT; i++) ct[i] = outq[i];
    chk("t4_ct0", 32'(ct[0]), 32'h0E);
    chk("t4_ct1", 32'(ct[1]), 32'h02);

    outq.delete();
    load_tbl(7, 1, junk);
    end_load();
    for (int i = 0; i < NPT; i++) send(ct[i], 1'b1);
    quiet(LAT + 2);
    chk("t4_dec_n", outq.size(), NPT);
    errs = 0;
    for (int i = 0; i < NPT; i++)
      if (outq[i] !== pt[i]) errs++;
    chk("t4_errs", errs, 0);

    // test 5: async reset mid-burst
    for (int i = 0; i < 3; i++) send('0, 1'b0);
    #1 srst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(bus.code_valid), 0);
    chk("t5_out", 32'(bus.code_out), 0);
    bus.encrypt = 1'b0;
    tick(1);
    srst_n = 1'b1;
    outq.delete();
    for (int i = 0; i < 3; i++) send('0, 1'b0);
    quiet(LAT + 2);
    chk("t5_ign", outq.size(), 0);

    // load then idle reaches READY; LOAD ignores encrypt
    bus.encrypt   = 1'b1;
    bus.load      = 1'b1;
    bus.table_idx = 3'd7;
    bus.code_in   = '0;
    tick(1);
    bus.load = 1'b0;
    tick(1);
    send('0, 1'b0);
    quiet(LAT + 2);
    chk("t5_n", outq.size(), 1);
    chk("t5_ct", 32'(outq[0]), 32'h0E);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
